// File: rtl/game_over_text_ctrl.sv
// game_over_text_ctrl
//   Draws a blinking "GAME OVER" overlay from an external font ROM.
//   A two-stage pixel pipeline maps (px, py) to a glyph/row/column lookup
//   and then to a registered overlay bit; a small FSM gates the overlay on
//   and off once per BLINK_FRAMES frames while game_over is held high.
//
// Ports
//   clk         sole clock, all state on rising edge
//   rst         synchronous, active-high reset
//   px, py      current pixel coordinates (10 bits each)
//   video_on    pixel lies in the visible area
//   frame_tick  one-cycle pulse per frame
//   game_over   level, high while the game is over
//   char_idx    glyph select to font ROM (0-8 = G,A,M,E,space,O,V,E,R)
//   row_idx     glyph row to font ROM
//   rom_bits    combinational font ROM row data, bit7 = leftmost pixel
//   text_pixel  overlay pixel on (2 cycles after px/py/video_on)
//   text_active high whenever the FSM is not IDLE
module game_over_text_ctrl #(
   parameter int unsigned TEXT_X0      = 248,
   parameter int unsigned TEXT_Y0      = 232,
   parameter int unsigned SCALE_SHIFT  = 1,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] px,
   input  logic [9:0] py,
   input  logic       video_on,
   input  logic       frame_tick,
   input  logic       game_over,
   output logic [3:0] char_idx,
   output logic [2:0] row_idx,
   input  logic [7:0] rom_bits,
   output logic       text_pixel,
   output logic       text_active
);

   localparam logic [10:0] X0         = 11'(TEXT_X0);
   localparam logic [10:0] Y0         = 11'(TEXT_Y0);
   localparam logic [10:0] CELL_W     = 11'(8 << SCALE_SHIFT);
   localparam logic [10:0] BOX_W      = 11'(9 * (8 << SCALE_SHIFT));
   localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);
   localparam logic [3:0]  CHAR_SPACE = 4'd4;

   typedef enum logic [1:0] {
      IDLE,
      SHOW_ON,
      SHOW_OFF
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  blink_cnt_q, blink_cnt_d;
   logic        text_active_q, text_active_d;

   logic        in_box_q, in_box_d;
   logic [3:0]  char_idx_q, char_idx_d;
   logic [2:0]  row_idx_q, row_idx_d;
   logic [2:0]  col_q, col_d;
   logic        text_pixel_q, text_pixel_d;

   logic [10:0] px_ext, py_ext;
   logic [10:0] dx, dy;
   logic        in_box;

   // ---------------------------------------------------------------
   // Blink FSM: game_over low wins over everything, including a tick.
   // ---------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      blink_cnt_d = blink_cnt_q;
      if (!game_over) begin
         state_d     = IDLE;
         blink_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d     = SHOW_ON;
               blink_cnt_d = '0;
            end
            SHOW_ON, SHOW_OFF: begin
               if (frame_tick) begin
                  if (blink_cnt_q == BLINK_LAST) begin
                     blink_cnt_d = '0;
                     state_d     = (state_q == SHOW_ON) ? SHOW_OFF : SHOW_ON;
                  end else begin
                     blink_cnt_d = blink_cnt_q + 8'd1;
                  end
               end
            end
            default: begin
               state_d     = IDLE;
               blink_cnt_d = '0;
            end
         endcase
      end
      // Decoded from the next state so text_active tracks the state register.
      text_active_d = (state_d != IDLE);
   end

   // ---------------------------------------------------------------
   // Stage 1: box test and glyph/row/column lookup.
   // dx/dy are 11 bits so a pixel left of / above the box wraps to a
   // large value; the explicit >= tests keep that from matching anyway.
   // ---------------------------------------------------------------
   always_comb begin
      px_ext = {1'b0, px};
      py_ext = {1'b0, py};
      dx     = px_ext - X0;
      dy     = py_ext - Y0;
      in_box = video_on && (px_ext >= X0) && (dx < BOX_W)
                        && (py_ext >= Y0) && (dy < CELL_W);

      in_box_d   = 1'b0;
      char_idx_d = CHAR_SPACE;
      row_idx_d  = '0;
      col_d      = '0;
      if (in_box) begin
         in_box_d   = 1'b1;
         char_idx_d = 4'(dx >> (3 + SCALE_SHIFT));
         row_idx_d  = 3'(dy >> SCALE_SHIFT);
         col_d      = 3'(dx >> SCALE_SHIFT);
      end
   end

   // ---------------------------------------------------------------
   // Stage 2: the ROM answers combinationally for the stage-1 registers,
   // so the overlay bit is selected here using the current blink state.
   // ---------------------------------------------------------------
   always_comb begin
      text_pixel_d = in_box_q && (state_q == SHOW_ON) && rom_bits[3'd7 - col_q];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         blink_cnt_q   <= '0;
         text_active_q <= 1'b0;
         in_box_q      <= 1'b0;
         char_idx_q    <= CHAR_SPACE;
         row_idx_q     <= '0;
         col_q         <= '0;
         text_pixel_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         blink_cnt_q   <= blink_cnt_d;
         text_active_q <= text_active_d;
         in_box_q      <= in_box_d;
         char_idx_q    <= char_idx_d;
         row_idx_q     <= row_idx_d;
         col_q         <= col_d;
         text_pixel_q  <= text_pixel_d;
      end
   end

   assign char_idx    = char_idx_q;
   assign row_idx     = row_idx_q;
   assign text_pixel  = text_pixel_q;
   assign text_active = text_active_q;

endmodule

// File: tb/tb_game_over_text_ctrl.sv
// tb_game_over_text_ctrl
//   Directed bench for game_over_text_ctrl with a behavioural 8x8 font ROM.
//   Inputs change on the falling edge; outputs are read on the falling edge.
module tb_game_over_text_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] px;
   logic [9:0] py;
   logic       video_on;
   logic       frame_tick;
   logic       game_over;
   logic [3:0] char_idx;
   logic [2:0] row_idx;
   logic [7:0] rom_bits;
   logic       text_pixel;
   logic       text_active;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   game_over_text_ctrl #(
      .TEXT_X0     (248),
      .TEXT_Y0     (232),
      .SCALE_SHIFT (1),
      .BLINK_FRAMES(30)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .px         (px),
      .py         (py),
      .video_on   (video_on),
      .frame_tick (frame_tick),
      .game_over  (game_over),
      .char_idx   (char_idx),
      .row_idx    (row_idx),
      .rom_bits   (rom_bits),
      .text_pixel (text_pixel),
      .text_active(text_active)
   );

   // Font ROM: one 64-bit word per glyph, row 0 in the top byte.
   logic [63:0] glyph_word;
   logic [63:0] glyph_row;
   always_comb begin
      case (char_idx)
         4'd0:    glyph_word = 64'h3C66C0CEC6663E00; // G
         4'd1:    glyph_word = 64'h183C667E66666600; // A
         4'd2:    glyph_word = 64'hC6EEFED6C6C6C600; // M
         4'd3:    glyph_word = 64'hFEC0C0FCC0C0FE00; // E
         4'd5:    glyph_word = 64'h7CC6C6C6C6C67C00; // O
         4'd6:    glyph_word = 64'hC6C6C6C6C66C3800; // V
         4'd7:    glyph_word = 64'hFEC0C0FCC0C0FE00; // E
         4'd8:    glyph_word = 64'hFC66667C6C66E600; // R
         default: glyph_word = 64'h0;                // space / unused
      endcase
      glyph_row = glyph_word >> {3'd7 - row_idx, 3'b000};
      rom_bits  = glyph_row[7:0];
   end

   task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic v,
                        output logic [3:0] ci, output logic [2:0] ri, output logic tp);
      px = x; py = y; video_on = v;
      @(negedge clk);
      ci = char_idx;
      ri = row_idx;
      @(negedge clk);
      tp = text_pixel;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         @(negedge clk);
         frame_tick = 1'b0;
         @(negedge clk);
      end
   endtask

   // Drop then re-raise game_over: leaves the FSM in SHOW_ON with blink_cnt=0.
   task automatic restart_show();
      game_over = 1'b0;
      @(negedge clk);
      game_over = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; game_over = 1'b1; frame_tick = 1'b0;
      px = 10'd252; py = 10'd232; video_on = 1'b1;
      @(negedge clk);
      total++; if (text_pixel !== 1'b0) begin bad++; $display("FAIL reset_pixel: got %b want 0", text_pixel); end
      total++; if (text_active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", text_active); end
      total++; if (char_idx !== 4'd4) begin bad++; $display("FAIL reset_char: got %0d want 4", char_idx); end
      total++; if (row_idx !== 3'd0) begin bad++; $display("FAIL reset_row: got %0d want 0", row_idx); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (text_active !== 1'b1) begin bad++; $display("FAIL reset_exit_active: got %b want 1", text_active); end
      total++; if (char_idx !== 4'd0) begin bad++; $display("FAIL reset_exit_char: got %0d want 0", char_idx); end
      @(negedge clk);
      total++; if (text_pixel !== 1'b1) begin bad++; $display("FAIL reset_exit_pixel: got %b want 1", text_pixel); end
   endtask

   task automatic test_glyph();
      logic [9:0] xs [6] = '{10'd248, 10'd252, 10'd250, 10'd264, 10'd270, 10'd389};
      logic [9:0] ys [6] = '{10'd232, 10'd232, 10'd234, 10'd232, 10'd232, 10'd244};
      logic [3:0] eci[6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd8};
      logic [2:0] eri[6] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd6};
      logic       etp[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [3:0] ci; logic [2:0] ri; logic tp;
      for (int i = 0; i < 6; i++) begin
         probe(xs[i], ys[i], 1'b1, ci, ri, tp);
         total++; if (ci !== eci[i]) begin bad++; $display("FAIL glyph_char[%0d]: got %0d want %0d", i, ci, eci[i]); end
         total++; if (ri !== eri[i]) begin bad++; $display("FAIL glyph_row[%0d]: got %0d want %0d", i, ri, eri[i]); end
         total++; if (tp !== etp[i]) begin bad++; $display("FAIL glyph_pixel[%0d]: got %b want %b", i, tp, etp[i]); end
      end
   endtask

   task automatic test_box_edges();
      logic [9:0] xs [7] = '{10'd247, 10'd392, 10'd391, 10'd252, 10'd252, 10'd252, 10'd248};
      logic [9:0] ys [7] = '{10'd232, 10'd232, 10'd232, 10'd232, 10'd231, 10'd248, 10'd247};
      logic       vs [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [3:0] eci[7] = '{4'd4, 4'd4, 4'd8, 4'd4, 4'd4, 4'd4, 4'd0};
      logic [2:0] eri[7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7};
      logic [3:0] ci; logic [2:0] ri; logic tp;
      for (int i = 0; i < 7; i++) begin
         probe(xs[i], ys[i], vs[i], ci, ri, tp);
         total++; if (ci !== eci[i]) begin bad++; $display("FAIL edge_char[%0d]: got %0d want %0d", i, ci, eci[i]); end
         total++; if (ri !== eri[i]) begin bad++; $display("FAIL edge_row[%0d]: got %0d want %0d", i, ri, eri[i]); end
         total++; if (tp !== 1'b0) begin bad++; $display("FAIL edge_pixel[%0d]: got %b want 0", i, tp); end
      end
   endtask

   // One new pixel every clock; each result must appear exactly 2 cycles later.
   task automatic test_back_to_back();
      logic [9:0] xs [13] = '{10'd248, 10'd249, 10'd250, 10'd251, 10'd252, 10'd253, 10'd254,
                              10'd255, 10'd246, 10'd247, 10'd392, 10'd389, 10'd386};
      logic       etp[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      py = 10'd232;
      for (int i = 0; i <= 13; i++) begin
         if (i < 13) begin
            px = xs[i]; video_on = 1'b1;
         end else begin
            video_on = 1'b0;
         end
         @(negedge clk);
         if (i >= 1) begin
            total++;
            if (text_pixel !== etp[i-1]) begin
               bad++; $display("FAIL stream_pixel[%0d]: got %b want %b", i - 1, text_pixel, etp[i-1]);
            end
         end
      end
   endtask

   task automatic test_blink();
      px = 10'd252; py = 10'd232; video_on = 1'b1;
      restart_show();
      ticks(29);
      total++; if (text_pixel !== 1'b1) begin bad++; $display("FAIL blink_29_on: got %b want 1", text_pixel); end
      ticks(1);
      total++; if (text_pixel !== 1'b0) begin bad++; $display("FAIL blink_off: got %b want 0", text_pixel); end
      total++; if (text_active !== 1'b1) begin bad++; $display("FAIL blink_off_active: got %b want 1", text_active); end
      ticks(29);
      total++; if (text_pixel !== 1'b0) begin bad++; $display("FAIL blink_29_off: got %b want 0", text_pixel); end
      ticks(1);
      total++; if (text_pixel !== 1'b1) begin bad++; $display("FAIL blink_on_again: got %b want 1", text_pixel); end
   endtask

   task automatic test_priority();
      px = 10'd252; py = 10'd232; video_on = 1'b1;
      restart_show();
      ticks(29);
      frame_tick = 1'b1; game_over = 1'b0;
      @(negedge clk);
      total++; if (text_active !== 1'b0) begin bad++; $display("FAIL prio_idle: got %b want 0", text_active); end
      frame_tick = 1'b0; game_over = 1'b1;
      @(negedge clk);
      total++; if (text_active !== 1'b1) begin bad++; $display("FAIL prio_rearm: got %b want 1", text_active); end
      ticks(29);
      total++; if (text_pixel !== 1'b1) begin bad++; $display("FAIL prio_full_on: got %b want 1", text_pixel); end
      ticks(1);
      total++; if (text_pixel !== 1'b0) begin bad++; $display("FAIL prio_then_off: got %b want 0", text_pixel); end
   endtask

   task automatic test_reset_mid_stream();
      px = 10'd252; py = 10'd232; video_on = 1'b1;
      // Mid SHOW_ON: pipeline is full of lit pixels when reset hits.
      restart_show();
      ticks(1);
      rst = 1'b1; game_over = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      total++; if (text_pixel !== 1'b0) begin bad++; $display("FAIL rston_pixel: got %b want 0", text_pixel); end
      total++; if (text_active !== 1'b0) begin bad++; $display("FAIL rston_active: got %b want 0", text_active); end
      total++; if (char_idx !== 4'd4) begin bad++; $display("FAIL rston_char: got %0d want 4", char_idx); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++; if (text_pixel !== 1'b0) begin bad++; $display("FAIL rston_hold[%0d]: got %b want 0", i, text_pixel); end
      end
      // Mid SHOW_OFF.
      game_over = 1'b1;
      restart_show();
      ticks(30);
      rst = 1'b1; game_over = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      total++; if (text_active !== 1'b0) begin bad++; $display("FAIL rstoff_active: got %b want 0", text_active); end
      for (int i = 0; i < 5; i++) begin
         total++; if (text_pixel !== 1'b0) begin bad++; $display("FAIL rstoff_hold[%0d]: got %b want 0", i, text_pixel); end
         @(negedge clk);
      end
      game_over = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++; if (text_pixel !== 1'b1) begin bad++; $display("FAIL rstoff_resume: got %b want 1", text_pixel); end
   endtask

   initial begin
      test_reset();
      test_glyph();
      test_box_edges();
      test_back_to_back();
      test_blink();
      test_priority();
      test_reset_mid_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/game_over_text_ctrl.md
GAME_OVER_TEXT_CTRL -- requirements
Module: game_over_text_ctrl

Interface
REQ-001 SHALL provide parameter TEXT_X0, 248, left pixel column of the text box.
REQ-002 SHALL provide parameter TEXT_Y0, 232, top pixel row of the text box.
REQ-003 SHALL provide parameter SCALE_SHIFT, 1, log2 glyph magnification (cell = 8<<SCALE_SHIFT px).
REQ-004 SHALL provide parameter BLINK_FRAMES, 30, frames per blink half-period (>=1).
REQ-005 SHALL provide port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL provide port px  input  10  current pixel x.
REQ-008 SHALL provide port py  input  10  current pixel y.
REQ-009 SHALL provide port video_on  input  1  pixel is in the visible area.
REQ-010 SHALL provide port frame_tick  input  1  one-cycle pulse per frame.
REQ-011 SHALL provide port game_over  input  1  level, high while the game is over.
REQ-012 SHALL provide port char_idx  output  4  glyph select to the font ROM (0-8 = G,A,M,E,space,O,V,E,R).
REQ-013 SHALL provide port row_idx  output  3  glyph row to the font ROM.
REQ-014 SHALL provide port rom_bits  input  8  combinational font ROM row data, bit7 = leftmost pixel.
REQ-015 SHALL provide port text_pixel  output  1  overlay pixel on.
REQ-016 SHALL provide port text_active  output  1  high whenever the FSM is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, SHOW_ON, SHOW_OFF, plus an 8-bit blink counter blink_cnt.
REQ-018 IDLE SHALL go to SHOW_ON on the cycle after game_over=1 is sampled, with blink_cnt=0.
REQ-019 In SHOW_ON/SHOW_OFF, a sampled frame_tick SHALL increment blink_cnt; a tick with blink_cnt=BLINK_FRAMES-1 SHALL instead clear blink_cnt and toggle SHOW_ON<->SHOW_OFF.
REQ-020 game_over=0 in any state SHALL force IDLE and blink_cnt=0 next cycle, taking priority over a coincident frame_tick.
REQ-021 Box definition: dx=px-TEXT_X0 and dy=py-TEXT_Y0, both computed 11 bits wide; in_box SHALL be true only for video_on=1, px>=TEXT_X0, dx<9*(8<<SCALE_SHIFT), py>=TEXT_Y0 and dy<(8<<SCALE_SHIFT).
REQ-022 Stage 1 (registered) SHALL capture in_box_q, char_idx=dx>>(3+SCALE_SHIFT), row_idx=(dy>>SCALE_SHIFT)&7 and col_q=(dx>>SCALE_SHIFT)&7.
REQ-023 When in_box is false, stage 1 SHALL load char_idx=4, row_idx=0, col_q=0 and in_box_q=0.
REQ-024 Stage 2 (registered) SHALL load text_pixel = in_box_q AND (state==SHOW_ON) AND rom_bits[7-col_q].
REQ-025 Latency from px/py/video_on to text_pixel SHALL be exactly 2 cycles, at full throughput (one pixel per clock, no stalls).
REQ-026 text_active SHALL be registered state decode (state!=IDLE).
REQ-027 Pixels at px=TEXT_X0-1, at px=TEXT_X0+9*cell, and at py outside [TEXT_Y0, TEXT_Y0+cell) SHALL yield text_pixel=0.

Reset
REQ-028 rst=1 SHALL set next cycle: state=IDLE, blink_cnt=0, char_idx=4, row_idx=0, col_q=0, in_box_q=0, text_pixel=0, text_active=0.
REQ-029 rst SHALL override all other inputs, including mid-blink and mid-pipeline; no stale pixel SHALL emerge after reset.

Verification
REQ-030 Reset: rst=1 for 1 cycle with game_over=1 -> text_pixel=0, text_active=0, char_idx=4; SHOW_ON reached 1 cycle after rst falls.
REQ-031 Glyph lookup (defaults, SHOW_ON): px=248,py=232 -> char_idx=0,row_idx=0, text_pixel=0 2 cycles later; px=252 -> text_pixel=1 (G row0 bit5).
REQ-032 Box edges: px=247 -> 0; px=392 -> 0, char_idx=4; px=391,py=232 -> char_idx=8, text_pixel=0 (R row0 bit0); video_on=0 inside box -> 0.
REQ-033 Blink: game_over=1, 30 frame_ticks -> SHOW_OFF, text_pixel=0 at px=252; 30 more -> SHOW_ON, text_pixel=1 again.
REQ-034 Priority: game_over falls on a cycle with frame_tick at blink_cnt=29 -> IDLE, blink_cnt=0; re-raise -> SHOW_ON lasting a full 30 frames.
REQ-035 Reset mid-SHOW_OFF while streaming in-box pixels -> IDLE next cycle, text_pixel=0 on every following cycle until game_over is re-sampled.
